// File: rtl/rob_req_tagger.sv
// Tags an in-order request stream with ROB IDs and steers out-of-order responses into the ROB write port.
// Optional macro ROB_TAGGER_RESP_REG_EN registers the response path (push one cycle after the response).
module rob_req_tagger #(
    parameter int DataWidth = 32,
    parameter int RespWidth = 32,
    parameter int NumWords  = 8,
    parameter int IdWidth   = $clog2(NumWords)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [DataWidth-1:0] req_data_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    output logic [DataWidth-1:0] mem_req_data_o,
    output logic [IdWidth-1:0]   mem_req_id_o,
    output logic                 mem_req_valid_o,
    input  logic                 mem_req_ready_i,
    input  logic [RespWidth-1:0] mem_resp_data_i,
    input  logic [IdWidth-1:0]   mem_resp_id_i,
    input  logic                 mem_resp_valid_i,
    output logic                 rob_id_req_o,
    input  logic [IdWidth-1:0]   rob_id_i,
    input  logic                 rob_full_i,
    output logic [RespWidth-1:0] rob_data_o,
    output logic [IdWidth-1:0]   rob_id_o,
    output logic                 rob_push_o,
    output logic [IdWidth:0]     outstanding_o,
    output logic                 err_o,
    output logic                 idle_o
);

    localparam logic [IdWidth:0] MaxOutstanding = (IdWidth+1)'(NumWords);
    localparam logic [IdWidth:0] CntOne         = (IdWidth+1)'(1);

    logic                 vld_p1;
    logic [DataWidth-1:0] req_data_p1;
    logic [IdWidth-1:0]   req_id_p1;
    logic                 stage_free;
    logic                 accept;
    logic                 resp_hit;
    logic                 resp_err;
    logic                 push;
    logic [IdWidth-1:0]   push_id;
    logic [RespWidth-1:0] push_data;
    logic [NumWords-1:0]  pending_q;
    logic [NumWords-1:0]  pending_d;
    logic [IdWidth:0]     outstanding_q;
    logic                 err_q;

    function automatic logic [IdWidth:0] count_next(input logic [IdWidth:0] cnt,
                                                     input logic inc, input logic dec);
        logic [IdWidth:0] res;
        res = cnt;
        if (inc && !dec) res = cnt + CntOne;
        else if (dec && !inc) res = cnt - CntOne;
        return res;
    endfunction

    assign stage_free   = !vld_p1 || mem_req_ready_i;
    assign req_ready_o  = stage_free && !rob_full_i && !pending_q[rob_id_i] &&
                          (outstanding_q < MaxOutstanding);
    assign accept       = req_valid_i && req_ready_o;
    assign rob_id_req_o = accept;

    // Stage p1: request register towards memory
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_p1 <= 1'b0;
        end else if (accept) begin
            vld_p1 <= 1'b1;
        end else if (mem_req_ready_i) begin
            vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            req_data_p1 <= req_data_i;
            req_id_p1   <= rob_id_i;
        end
    end

`ifdef ROB_TAGGER_RESP_REG_EN
    logic                 push_vld_p1;
    logic [IdWidth-1:0]   push_id_p1;
    logic [RespWidth-1:0] push_data_p1;

    // An ID already captured for push counts as answered even though its pending bit clears next edge.
    assign resp_hit = mem_resp_valid_i && pending_q[mem_resp_id_i] &&
                      !(push_vld_p1 && (push_id_p1 == mem_resp_id_i));

    // Stage p1: registered response towards the ROB
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            push_vld_p1 <= 1'b0;
        end else begin
            push_vld_p1 <= resp_hit;
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_resp_valid_i) begin
            push_id_p1   <= mem_resp_id_i;
            push_data_p1 <= mem_resp_data_i;
        end
    end

    assign push      = push_vld_p1;
    assign push_id   = push_id_p1;
    assign push_data = push_data_p1;
`else
    assign resp_hit  = mem_resp_valid_i && pending_q[mem_resp_id_i];
    assign push      = resp_hit;
    assign push_id   = mem_resp_id_i;
    assign push_data = mem_resp_data_i;
`endif

    assign resp_err = mem_resp_valid_i && !resp_hit;

    always_comb begin
        pending_d = pending_q;
        if (push) pending_d[push_id] = 1'b0;
        if (accept) pending_d[rob_id_i] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q     <= '0;
            outstanding_q <= '0;
            err_q         <= 1'b0;
        end else begin
            pending_q     <= pending_d;
            outstanding_q <= count_next(outstanding_q, accept, push);
            if (resp_err) err_q <= 1'b1;
        end
    end

    assign mem_req_valid_o = vld_p1;
    assign mem_req_data_o  = req_data_p1;
    assign mem_req_id_o    = req_id_p1;
    assign rob_push_o      = push;
    assign rob_id_o        = push_id;
    assign rob_data_o      = push_data;
    assign outstanding_o   = outstanding_q;
    assign err_o           = err_q;
    assign idle_o          = (outstanding_q == '0) && !vld_p1;

endmodule

// File: tb/tb_rob_req_tagger.sv
// Scoreboard bench for rob_req_tagger: a set-based ID model predicts requests, pushes and status outputs.
module tb_rob_req_tagger;
    localparam int DW = 32;
    localparam int RW = 32;
    localparam int NW = 8;
    localparam int IW = 3;
`ifdef ROB_TAGGER_RESP_REG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    typedef struct {
        logic [DW-1:0] data;
        logic [IW-1:0] id;
    } req_t;

    typedef struct {
        logic [RW-1:0] data;
        logic [IW-1:0] id;
        int            at;
    } push_t;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic [DW-1:0] req_data_i = '0;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic [DW-1:0] mem_req_data_o;
    logic [IW-1:0] mem_req_id_o;
    logic          mem_req_valid_o;
    logic          mem_req_ready_i = 1'b0;
    logic [RW-1:0] mem_resp_data_i = '0;
    logic [IW-1:0] mem_resp_id_i = '0;
    logic          mem_resp_valid_i = 1'b0;
    logic          rob_id_req_o;
    logic [IW-1:0] rob_id_i = '0;
    logic          rob_full_i = 1'b0;
    logic [RW-1:0] rob_data_o;
    logic [IW-1:0] rob_id_o;
    logic          rob_push_o;
    logic [IW:0]   outstanding_o;
    logic          err_o;
    logic          idle_o;

    rob_req_tagger #(.DataWidth(DW), .RespWidth(RW), .NumWords(NW)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_data_i(req_data_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .mem_req_data_o(mem_req_data_o), .mem_req_id_o(mem_req_id_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_resp_data_i(mem_resp_data_i), .mem_resp_id_i(mem_resp_id_i),
        .mem_resp_valid_i(mem_resp_valid_i),
        .rob_id_req_o(rob_id_req_o), .rob_id_i(rob_id_i), .rob_full_i(rob_full_i),
        .rob_data_o(rob_data_o), .rob_id_o(rob_id_o), .rob_push_o(rob_push_o),
        .outstanding_o(outstanding_o), .err_o(err_o), .idle_o(idle_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_err = 0;

    req_t  exp_req_q[$];
    push_t exp_push_q[$];

    // Reference model: IDs awaiting a response, IDs still blocking reuse, release times, stage occupancy.
    bit aw[NW];
    bit bz[NW];
    int rel[NW];
    bit m_stg;
    bit m_err;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < NW; i++) begin
            aw[i] = 1'b0;
            bz[i] = 1'b0;
            rel[i] = -1;
        end
        m_stg = 1'b0;
        m_err = 1'b0;
        exp_req_q.delete();
        exp_push_q.delete();
    endfunction

    // Monitor: pops expectations whenever the DUT presents a memory handshake or a ROB push.
    always @(negedge clk) begin
        push_t e;
        req_t  r;
        if (rst_ni) begin
            if (rob_push_o) begin
                if (exp_push_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_push: got id %0d data %0h, required no push (cycle %0d)",
                             rob_id_o, rob_data_o, cyc);
                end else begin
                    e = exp_push_q.pop_front();
                    chk("push_id", rob_id_o, e.id);
                    chk("push_data", rob_data_o, e.data);
                    chk("push_cycle", cyc, e.at);
                end
            end
            if (mem_req_valid_o && mem_req_ready_i) begin
                if (exp_req_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_mem_req: got id %0d, required no request (cycle %0d)",
                             mem_req_id_o, cyc);
                end else begin
                    r = exp_req_q.pop_front();
                    chk("mem_req_id", mem_req_id_o, r.id);
                    chk("mem_req_data", mem_req_data_o, r.data);
                end
            end
        end
    end

    task automatic cycle(input bit rv, input logic [DW-1:0] d, input int rid, input bit full,
                         input bit mrdy, input bit sv, input int sid, input logic [RW-1:0] sd,
                         output bit acc);
        int cnt;
        bit ready_m;
        @(posedge clk);
        #1;
        req_valid_i = rv; req_data_i = d; rob_id_i = IW'(rid); rob_full_i = full;
        mem_req_ready_i = mrdy;
        mem_resp_valid_i = sv; mem_resp_id_i = IW'(sid); mem_resp_data_i = sd;
        for (int i = 0; i < NW; i++) begin
            if (rel[i] == cyc) begin
                bz[i] = 1'b0;
                rel[i] = -1;
            end
        end
        cnt = 0;
        for (int i = 0; i < NW; i++) cnt += int'(bz[i]);
        ready_m = (!m_stg || mrdy) && !full && !bz[rid] && (cnt < NW);
        acc = rv && ready_m;
        #1;
        chk("req_ready", req_ready_o, ready_m);
        chk("rob_id_req", rob_id_req_o, acc);
        chk("mem_req_valid", mem_req_valid_o, m_stg);
        chk("outstanding", outstanding_o, cnt);
        chk("idle", idle_o, (cnt == 0) && !m_stg);
        chk("err", err_o, m_err);
        if (sv) begin
            if (aw[sid]) begin
                aw[sid] = 1'b0;
                rel[sid] = cyc + 1 + LAT;
                exp_push_q.push_back('{sd, IW'(sid), cyc + LAT});
            end else begin
                m_err = 1'b1;
            end
        end
        if (acc) begin
            bz[rid] = 1'b1;
            aw[rid] = 1'b1;
            exp_req_q.push_back('{d, IW'(rid)});
        end
        m_stg = acc ? 1'b1 : (mrdy ? 1'b0 : m_stg);
    endtask

    task automatic drain();
        bit acc;
        for (int i = 0; i < 4; i++) cycle(0, '0, 0, 0, 1, 0, 0, '0, acc);
        chk("req_queue_drained", exp_req_q.size(), 0);
        chk("push_queue_drained", exp_push_q.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_ni = 1'b0;
        req_valid_i = 1'b0; mem_req_ready_i = 1'b0;
        mem_resp_valid_i = 1'b1; mem_resp_id_i = '0;
        #1;
        chk("rst_mem_req_valid", mem_req_valid_o, 0);
        chk("rst_rob_push", rob_push_o, 0);
        chk("rst_outstanding", outstanding_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_idle", idle_o, 1);
        model_clear();
        @(posedge clk);
        #1 mem_resp_valid_i = 1'b0;
        @(posedge clk);
        #1 rst_ni = 1'b1;
    endtask

    initial begin
        bit acc;
        int nid;
        int sid;
        int bad_pct;
        int cand[$];

        model_clear();
        do_reset();

        // First request, then three more with memory backpressure after the first issue
        cycle(1, 32'hA5, 0, 0, 1, 0, 0, '0, acc);
        chk("first_accept", acc, 1);
        nid = 1;
        for (int k = 0; k < 8; k++) begin
            cycle(nid < 4, $urandom, nid, 0, (k < 1) || (k >= 4), 0, 0, '0, acc);
            if (acc) nid++;
        end
        chk("four_ids_issued", nid, 4);

        // Out-of-order responses, then a response for an ID that was never issued
        cycle(0, '0, 0, 0, 1, 1, 2, 32'h2222, acc);
        cycle(0, '0, 0, 0, 1, 1, 0, 32'h0000_1000, acc);
        cycle(0, '0, 0, 0, 1, 1, 3, 32'h3333, acc);
        cycle(0, '0, 0, 0, 1, 1, 1, 32'h1111, acc);
        cycle(0, '0, 0, 0, 1, 1, 5, 32'hBAD, acc);
        for (int k = 0; k < 3; k++) cycle(0, '0, 0, 0, 1, 0, 0, '0, acc);

        // ROB full blocks allocation; releasing it accepts in the same cycle
        cycle(1, 32'h77, 0, 1, 1, 0, 0, '0, acc);
        cycle(1, 32'h77, 0, 0, 1, 0, 0, '0, acc);
        chk("accept_after_full", acc, 1);

        // Three IDs outstanding with the stage held full, then reset mid-operation
        cycle(1, 32'h44, 4, 0, 1, 1, 0, 32'hC0, acc);
        cycle(1, 32'h55, 5, 0, 1, 0, 0, '0, acc);
        cycle(1, 32'h66, 6, 0, 1, 0, 0, '0, acc);
        cycle(0, '0, 0, 0, 0, 0, 0, '0, acc);
        do_reset();
        cycle(1, 32'h5A, 2, 0, 1, 0, 0, '0, acc);
        chk("accept_after_reset", acc, 1);
        drain();

        // Randomized phases with increasing share of unexpected response IDs
        for (int ph = 0; ph < 4; ph++) begin
            bad_pct = ph * 4;
            for (int k = 0; k < 400; k++) begin
                cand.delete();
                for (int i = 0; i < NW; i++) if (aw[i]) cand.push_back(i);
                if (cand.size() > 0 && $urandom_range(0, 99) >= bad_pct)
                    sid = cand[$urandom_range(0, cand.size() - 1)];
                else
                    sid = $urandom_range(0, NW - 1);
                cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, NW - 1),
                      $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0,
                      $urandom_range(0, 2) == 0, sid, $urandom, acc);
            end
            drain();
            do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/rob_req_tagger.md
Name: rob_req_tagger

Overview:
- Sits directly upstream of the reorder buffer; tags an in-order request stream with ROB IDs and issues it to an out-of-order memory port.
- Allocates one ROB ID per accepted request and registers the tagged request towards memory.
- Tracks pending IDs and forwards each out-of-order response into the ROB write port by ID.
- The ROB then returns responses in request order.

Parameters:
- DataWidth, 32, request payload width.
- RespWidth, 32, response payload width.
- NumWords, 8, ROB depth; must equal the ROB's NumWords; must be >= 2.
- IdWidth, clog2(NumWords), derived; do not override.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_data_i  in  DataWidth  upstream request payload.
- req_valid_i  in  1  upstream request valid.
- req_ready_o  out  1  upstream request ready.
- mem_req_data_o  out  DataWidth  tagged request payload.
- mem_req_id_o  out  IdWidth  tag (ROB ID) of the request.
- mem_req_valid_o  out  1  memory request valid.
- mem_req_ready_i  in  1  memory request ready.
- mem_resp_data_i  in  RespWidth  response payload; arrives out of order.
- mem_resp_id_i  in  IdWidth  response tag.
- mem_resp_valid_i  in  1  response valid; no backpressure.
- rob_id_req_o  out  1  ID allocation request to the ROB.
- rob_id_i  in  IdWidth  next free ROB ID.
- rob_full_i  in  1  ROB cannot allocate.
- rob_data_o  out  RespWidth  ROB write data.
- rob_id_o  out  IdWidth  ROB write ID.
- rob_push_o  out  1  ROB write strobe.
- outstanding_o  out  IdWidth+1  IDs allocated and not yet pushed.
- err_o  out  1  sticky: response carried a non-pending ID.
- idle_o  out  1  no outstanding IDs and output stage empty.

Behaviour:
- Reset (rst_ni low, at any time, including mid-operation): clears all state.
  - Output reset values: mem_req_valid_o=0, rob_push_o=0, outstanding_o=0, err_o=0, idle_o=1, pending vector all 0.
  - In-flight requests and responses are discarded.
- Output stage: one register holding {data, id, valid}.
  - stage_free = !valid_q || mem_req_ready_i.
- Accept condition: req_ready_o = stage_free && !rob_full_i && !pending_q[rob_id_i] && (outstanding_q < NumWords).
- Accept = req_valid_i && req_ready_o. rob_id_req_o = accept, combinational in the same cycle; it is never asserted without an accept.
- On accept:
  - The register loads req_data_i and rob_id_i, and valid_q is set.
  - pending_q[rob_id_i] is set.
  - Request latency: mem_req_valid_o is asserted 1 cycle after accept.
- On mem_req_ready_i with no new accept: valid_q clears.
- While valid_q=1 and mem_req_ready_i=0: mem_req_data_o and mem_req_id_o hold stable.
- Back-to-back accepts run at full throughput when mem_req_ready_i is held high.
- Response check: evaluated against pending_q (the pre-update value).
  - Valid response (pending_q[id]=1): clears the pending bit and produces a push of {data, id}.
  - Invalid response (pending_q[id]=0): dropped with no push; err_o is set and stays set until reset.
- Response timing: see Optional Feature.
- outstanding counter:
  - +1 on accept; -1 on rob_push_o.
  - Accept and push in the same cycle: unchanged.
  - Never wraps; bounded by NumWords.
- Same ID in one cycle: accept of ID x is blocked while pending_q[x]=1. A response freeing x in cycle t allows reallocation of x from cycle t+1.
- idle_o = (outstanding_q == 0) && !valid_q.

Optional Feature:
- Macro: ROB_TAGGER_RESP_REG_EN.
- Defined:
  - The response path is registered.
  - rob_push_o, rob_data_o and rob_id_o are asserted 1 cycle after mem_resp_valid_i.
  - The pending-bit clear and the counter decrement occur when the push is issued.
- Undefined:
  - Push is combinational: rob_push_o = mem_resp_valid_i && pending_q[mem_resp_id_i], in the same cycle, with data and ID passed through.
- Both variants: identical error behaviour and identical accept rules.

Test Plan:
- Reset, then req_valid_i=1 with data 0xA5, rob_id_i=0, ready high -> rob_id_req_o=1 in cycle 0; mem_req_valid_o=1 with data 0xA5, id 0 in cycle 1; outstanding_o=1.
- 4 back-to-back requests (IDs 0..3) with mem_req_ready_i=0 after the first issue -> req_ready_o=0 while the stage is full; mem_req_id_o holds 1 stable until ready rises; no ID is lost or duplicated.
- Responses for IDs 2,0,3,1 arrive out of order -> 4 pushes with matching IDs and data; outstanding_o counts 4 down to 0; idle_o=1 at the end.
- Response with id 5 while only 0..3 are pending -> no rob_push_o; err_o=1 and stays set until reset.
- rob_full_i=1 with req_valid_i=1 -> req_ready_o=0 and rob_id_req_o=0; rob_full_i=0 -> accept in that same cycle.
- Assert rst_ni low with 3 IDs outstanding and the stage full -> all outputs return to reset values immediately; a new request after reset is accepted normally.
